// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: ALU operation codes, opcode/funct/rt fields,
// and the decoded control bundle carried from ID into EX.
package mips_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_NOR  = 5'b00100;
  localparam logic [4:0] ALU_SUB  = 5'b00101;
  localparam logic [4:0] ALU_ANDI = 5'b00110;
  localparam logic [4:0] ALU_XORI = 5'b00111;
  localparam logic [4:0] ALU_ORI  = 5'b01000;
  localparam logic [4:0] ALU_JR   = 5'b01001;
  localparam logic [4:0] ALU_BEQ  = 5'b01010;
  localparam logic [4:0] ALU_BNE  = 5'b01011;
  localparam logic [4:0] ALU_BGEZ = 5'b01100;
  localparam logic [4:0] ALU_BGTZ = 5'b01101;
  localparam logic [4:0] ALU_BLEZ = 5'b01110;
  localparam logic [4:0] ALU_BLTZ = 5'b01111;
  localparam logic [4:0] ALU_SLL  = 5'b10000;
  localparam logic [4:0] ALU_SRL  = 5'b10001;
  localparam logic [4:0] ALU_SRA  = 5'b10010;
  localparam logic [4:0] ALU_SLT  = 5'b10011;
  localparam logic [4:0] ALU_SLTU = 5'b10100;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef struct packed {
    logic [4:0]  aluCode;
    logic        aluSrcA;
    logic        aluSrcB;
    logic [31:0] immExt;
    logic [4:0]  shamt;
    logic        regWrite;
    logic        regDst;
    logic        memRead;
    logic        memWrite;
    logic        ovfEn;
    logic        illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // A bubble is all-zero control except the ALU code, which the EX stage expects to idle on.
  function automatic ctrl_t bubbleCtrl(input logic [4:0] code);
    ctrl_t c;
    c         = '0;
    c.aluCode = code;
    return c;
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Purely combinational MIPS instruction decode producing the ID/EX control bundle.
module id_decode_comb
  import mips_pkg::*;
#(
  parameter logic [4:0] RESET_CODE = 5'b00000
) (
  input  logic [31:0]       Instruction,
  output logic [CTRL_W-1:0] Ctrl
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic       w_unused;
  ctrl_t      w_ctrl;
  logic       w_legal;
  logic       w_iType;

  assign w_op     = Instruction[31:26];
  assign w_fn     = Instruction[5:0];
  assign w_rt     = Instruction[20:16];
  assign w_unused = ^Instruction[25:21];
  assign Ctrl     = w_ctrl;

  always_comb begin
    w_ctrl        = '0;
    w_legal       = 1'b1;
    w_iType       = 1'b0;
    w_ctrl.shamt  = Instruction[10:6];
    w_ctrl.immExt = {{16{Instruction[15]}}, Instruction[15:0]};

    case (w_op)
      OP_RTYPE: begin
        w_ctrl.regDst   = 1'b1;
        w_ctrl.regWrite = 1'b1;
        case (w_fn)
          FN_ADD:  begin w_ctrl.aluCode = ALU_ADD; w_ctrl.ovfEn = 1'b1; end
          FN_ADDU: w_ctrl.aluCode = ALU_ADD;
          FN_SUB:  begin w_ctrl.aluCode = ALU_SUB; w_ctrl.ovfEn = 1'b1; end
          FN_SUBU: w_ctrl.aluCode = ALU_SUB;
          FN_AND:  w_ctrl.aluCode = ALU_AND;
          FN_OR:   w_ctrl.aluCode = ALU_OR;
          FN_XOR:  w_ctrl.aluCode = ALU_XOR;
          FN_NOR:  w_ctrl.aluCode = ALU_NOR;
          FN_SLT:  w_ctrl.aluCode = ALU_SLT;
          FN_SLTU: w_ctrl.aluCode = ALU_SLTU;
          FN_SLL:  begin w_ctrl.aluCode = ALU_SLL; w_ctrl.aluSrcA = 1'b1; end
          FN_SLLV: w_ctrl.aluCode = ALU_SLL;
          FN_SRL:  begin w_ctrl.aluCode = ALU_SRL; w_ctrl.aluSrcA = 1'b1; end
          FN_SRLV: w_ctrl.aluCode = ALU_SRL;
          FN_SRA:  begin w_ctrl.aluCode = ALU_SRA; w_ctrl.aluSrcA = 1'b1; end
          FN_SRAV: w_ctrl.aluCode = ALU_SRA;
          FN_JR:   begin w_ctrl.aluCode = ALU_JR; w_ctrl.regWrite = 1'b0; end
          default: w_legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin w_iType = 1'b1; w_ctrl.aluCode = ALU_ADD; w_ctrl.ovfEn = 1'b1; end
      OP_ADDIU: begin w_iType = 1'b1; w_ctrl.aluCode = ALU_ADD; end
      OP_SLTI:  begin w_iType = 1'b1; w_ctrl.aluCode = ALU_SLT; end
      OP_SLTIU: begin w_iType = 1'b1; w_ctrl.aluCode = ALU_SLTU; end
      OP_ANDI:  begin w_iType = 1'b1; w_ctrl.aluCode = ALU_ANDI; w_ctrl.immExt = {16'h0000, Instruction[15:0]}; end
      OP_ORI:   begin w_iType = 1'b1; w_ctrl.aluCode = ALU_ORI;  w_ctrl.immExt = {16'h0000, Instruction[15:0]}; end
      OP_XORI:  begin w_iType = 1'b1; w_ctrl.aluCode = ALU_XORI; w_ctrl.immExt = {16'h0000, Instruction[15:0]}; end
      OP_LW:    begin w_iType = 1'b1; w_ctrl.aluCode = ALU_ADD; w_ctrl.memRead = 1'b1; end
      OP_SW:    begin w_iType = 1'b1; w_ctrl.aluCode = ALU_ADD; w_ctrl.memWrite = 1'b1; end
      OP_BEQ:   w_ctrl.aluCode = ALU_BEQ;
      OP_BNE:   w_ctrl.aluCode = ALU_BNE;
      OP_BLEZ:  w_ctrl.aluCode = ALU_BLEZ;
      OP_BGTZ:  w_ctrl.aluCode = ALU_BGTZ;
      OP_REGIMM: begin
        if (w_rt == RT_BGEZ)      w_ctrl.aluCode = ALU_BGEZ;
        else if (w_rt == RT_BLTZ) w_ctrl.aluCode = ALU_BLTZ;
        else                      w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase

    // Stores are the only immediate-operand instruction that does not write a register.
    if (w_iType) begin
      w_ctrl.aluSrcB  = 1'b1;
      w_ctrl.regWrite = ~w_ctrl.memWrite;
    end

    if (!w_legal) begin
      w_ctrl.aluCode  = RESET_CODE;
      w_ctrl.aluSrcA  = 1'b0;
      w_ctrl.aluSrcB  = 1'b0;
      w_ctrl.regDst   = 1'b0;
      w_ctrl.regWrite = 1'b0;
      w_ctrl.memRead  = 1'b0;
      w_ctrl.memWrite = 1'b0;
      w_ctrl.ovfEn    = 1'b0;
      w_ctrl.illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_decoder.sv
// ID/EX pipeline register around the combinational decoder, with
// reset > flush > stall > load priority and bubble insertion.
module id_ex_decoder
  import mips_pkg::*;
#(
  parameter logic [4:0] RESET_CODE = 5'b00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        ValidIn,
  input  logic        Stall,
  input  logic        Flush,
  output logic [4:0]  ALUCode,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic [31:0] ImmExt,
  output logic [4:0]  Shamt,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        OvfEn,
  output logic        ValidOut,
  output logic        Illegal
);

  logic [CTRL_W-1:0] w_decBits;
  ctrl_t             w_dec;
  ctrl_t             r_ctrl;
  logic              r_valid;

  id_decode_comb #(
    .RESET_CODE (RESET_CODE)
  ) uDecode (
    .Instruction (Instruction),
    .Ctrl        (w_decBits)
  );

  assign w_dec = w_decBits;

  // Flush wins over stall so a squashed instruction never lingers in EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl  <= bubbleCtrl(RESET_CODE);
      r_valid <= 1'b0;
    end else if (Flush) begin
      r_ctrl  <= bubbleCtrl(RESET_CODE);
      r_valid <= 1'b0;
    end else if (!Stall) begin
      if (ValidIn) begin
        r_ctrl  <= w_dec;
        r_valid <= 1'b1;
      end else begin
        r_ctrl  <= bubbleCtrl(RESET_CODE);
        r_valid <= 1'b0;
      end
    end
  end

  assign ALUCode  = r_ctrl.aluCode;
  assign ALUSrcA  = r_ctrl.aluSrcA;
  assign ALUSrcB  = r_ctrl.aluSrcB;
  assign ImmExt   = r_ctrl.immExt;
  assign Shamt    = r_ctrl.shamt;
  assign RegWrite = r_ctrl.regWrite;
  assign RegDst   = r_ctrl.regDst;
  assign MemRead  = r_ctrl.memRead;
  assign MemWrite = r_ctrl.memWrite;
  assign OvfEn    = r_ctrl.ovfEn;
  assign Illegal  = r_ctrl.illegal;
  assign ValidOut = r_valid;

endmodule

// File: tb/tb_id_ex_decoder.sv
// Self-checking bench: directed steps then randomized traffic against a
// mnemonic-level reference model of the ID/EX decode stage.
module tb_id_ex_decoder;

  localparam logic [4:0] RC = 5'b11111;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction;
  logic        ValidIn;
  logic        Stall;
  logic        Flush;
  logic [4:0]  ALUCode;
  logic        ALUSrcA;
  logic        ALUSrcB;
  logic [31:0] ImmExt;
  logic [4:0]  Shamt;
  logic        RegWrite;
  logic        RegDst;
  logic        MemRead;
  logic        MemWrite;
  logic        OvfEn;
  logic        ValidOut;
  logic        Illegal;

  int total;
  int bad;

  typedef struct {
    logic [4:0]  alu;
    logic        srcA;
    logic        srcB;
    logic [31:0] imm;
    logic [4:0]  sh;
    logic        rw;
    logic        rd;
    logic        mr;
    logic        mw;
    logic        ovf;
    logic        ill;
    logic        vld;
    bit          careRd;
    bit          careAll;
  } exp_t;

  exp_t expState;

  id_ex_decoder #(
    .RESET_CODE (RC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Instruction (Instruction),
    .ValidIn     (ValidIn),
    .Stall       (Stall),
    .Flush       (Flush),
    .ALUCode     (ALUCode),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ImmExt      (ImmExt),
    .Shamt       (Shamt),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .OvfEn       (OvfEn),
    .ValidOut    (ValidOut),
    .Illegal     (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t bubbleExp();
    exp_t e;
    e = '{alu: RC, srcA: 0, srcB: 0, imm: 0, sh: 0, rw: 0, rd: 0, mr: 0, mw: 0,
          ovf: 0, ill: 0, vld: 0, careRd: 1, careAll: 1};
    return e;
  endfunction

  function automatic string mnemonic(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    op = w[31:26];
    fn = w[5:0];
    rt = w[20:16];
    if (op == 6'd0) begin
      case (fn)
        6'h20: return "add";   6'h21: return "addu";
        6'h22: return "sub";   6'h23: return "subu";
        6'h24: return "and";   6'h25: return "or";
        6'h26: return "xor";   6'h27: return "nor";
        6'h2a: return "slt";   6'h2b: return "sltu";
        6'h00: return "sll";   6'h04: return "sllv";
        6'h02: return "srl";   6'h06: return "srlv";
        6'h03: return "sra";   6'h07: return "srav";
        6'h08: return "jr";
        default: return "ill";
      endcase
    end
    case (op)
      6'h08: return "addi";  6'h09: return "addiu";
      6'h0c: return "andi";  6'h0d: return "ori";
      6'h0e: return "xori";  6'h0a: return "slti";
      6'h0b: return "sltiu"; 6'h23: return "lw";
      6'h2b: return "sw";    6'h04: return "beq";
      6'h05: return "bne";   6'h06: return "blez";
      6'h07: return "bgtz";
      6'h01: begin
        if (rt == 5'd1) return "bgez";
        if (rt == 5'd0) return "bltz";
        return "ill";
      end
      default: return "ill";
    endcase
  endfunction

  function automatic exp_t refDecode(input logic [31:0] w);
    exp_t  e;
    string mn;
    bit    isR;
    bit    isBr;
    bit    isImm;
    mn = mnemonic(w);
    e  = bubbleExp();
    e.vld = 1;
    e.sh  = w[10:6];
    e.imm = {{16{w[15]}}, w[15:0]};
    if (mn == "ill") begin
      e.ill     = 1;
      e.careAll = 0;
      return e;
    end
    isR   = (w[31:26] == 6'd0);
    isBr  = (mn == "beq" || mn == "bne" || mn == "blez" || mn == "bgtz" ||
             mn == "bgez" || mn == "bltz");
    isImm = !isR && !isBr;
    case (mn)
      "add", "addu", "addi", "addiu", "lw", "sw": e.alu = 5'd0;
      "and":  e.alu = 5'd1;   "xor":  e.alu = 5'd2;
      "or":   e.alu = 5'd3;   "nor":  e.alu = 5'd4;
      "sub", "subu": e.alu = 5'd5;
      "andi": e.alu = 5'd6;   "xori": e.alu = 5'd7;
      "ori":  e.alu = 5'd8;   "jr":   e.alu = 5'd9;
      "beq":  e.alu = 5'd10;  "bne":  e.alu = 5'd11;
      "bgez": e.alu = 5'd12;  "bgtz": e.alu = 5'd13;
      "blez": e.alu = 5'd14;  "bltz": e.alu = 5'd15;
      "sll", "sllv": e.alu = 5'd16;
      "srl", "srlv": e.alu = 5'd17;
      "sra", "srav": e.alu = 5'd18;
      "slt", "slti": e.alu = 5'd19;
      default: e.alu = 5'd20;
    endcase
    e.srcA   = (mn == "sll" || mn == "srl" || mn == "sra");
    e.srcB   = isImm;
    e.rd     = isR;
    e.careRd = !isBr;
    e.rw     = (isR && mn != "jr") || (isImm && mn != "sw");
    e.mr     = (mn == "lw");
    e.mw     = (mn == "sw");
    e.ovf    = (mn == "add" || mn == "sub" || mn == "addi");
    if (mn == "andi" || mn == "ori" || mn == "xori") e.imm = {16'h0, w[15:0]};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".ALUCode"},  {27'd0, ALUCode},  {27'd0, expState.alu});
    chk({tag, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, expState.rw});
    chk({tag, ".MemRead"},  {31'd0, MemRead},  {31'd0, expState.mr});
    chk({tag, ".MemWrite"}, {31'd0, MemWrite}, {31'd0, expState.mw});
    chk({tag, ".OvfEn"},    {31'd0, OvfEn},    {31'd0, expState.ovf});
    chk({tag, ".ValidOut"}, {31'd0, ValidOut}, {31'd0, expState.vld});
    chk({tag, ".Illegal"},  {31'd0, Illegal},  {31'd0, expState.ill});
    chk({tag, ".Shamt"},    {27'd0, Shamt},    {27'd0, expState.sh});
    if (expState.careAll) begin
      chk({tag, ".ALUSrcA"}, {31'd0, ALUSrcA}, {31'd0, expState.srcA});
      chk({tag, ".ALUSrcB"}, {31'd0, ALUSrcB}, {31'd0, expState.srcB});
      chk({tag, ".ImmExt"},  ImmExt,           expState.imm);
      if (expState.careRd)
        chk({tag, ".RegDst"}, {31'd0, RegDst}, {31'd0, expState.rd});
    end
  endtask

  // Drive one cycle of inputs, advance the model through the edge, then compare.
  task automatic applyStimulus(input string tag, input logic [31:0] instr, input logic vin,
                               input logic stl, input logic fl, input logic rst);
    Instruction = instr;
    ValidIn     = vin;
    Stall       = stl;
    Flush       = fl;
    reset       = rst;
    @(posedge clk);
    if (rst)       expState = bubbleExp();
    else if (fl)   expState = bubbleExp();
    else if (!stl) expState = vin ? refDecode(instr) : bubbleExp();
    #1;
    checkOutput(tag);
  endtask

  logic [5:0] opList [16] = '{6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                             6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h3f};
  logic [5:0] fnList [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                             6'h2b, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h08, 6'h3f};

  initial begin
    logic [31:0] w;
    total       = 0;
    bad         = 0;
    expState    = bubbleExp();
    reset       = 1'b1;
    Instruction = 32'h0;
    ValidIn     = 1'b0;
    Stall       = 1'b0;
    Flush       = 1'b0;

    applyStimulus("reset0", 32'h00221820, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus("reset1", 32'h00221820, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset.ALUCodeConst", {27'd0, ALUCode}, {27'd0, RC});

    applyStimulus("add", 32'h00221820, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("add.ALUCodeConst", {27'd0, ALUCode}, 32'd0);
    chk("add.OvfEnConst", {31'd0, OvfEn}, 32'd1);

    applyStimulus("ori", 32'h3422FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ori.ImmConst", ImmExt, 32'h0000FFFF);

    applyStimulus("stall1", 32'h2022FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus("stall2", 32'h00021883, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("stall3", 32'hFC000000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall.ImmConst", ImmExt, 32'h0000FFFF);

    applyStimulus("addi", 32'h2022FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("addi.ImmConst", ImmExt, 32'hFFFFFFFF);

    applyStimulus("sra", 32'h00021883, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sra.ShamtConst", {27'd0, Shamt}, 32'd2);
    chk("sra.ALUCodeConst", {27'd0, ALUCode}, 32'h12);

    applyStimulus("bgez", 32'h04210004, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bgez.ALUCodeConst", {27'd0, ALUCode}, 32'h0C);

    applyStimulus("flushStall", 32'h00221820, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flushStall.ValidConst", {31'd0, ValidOut}, 32'd0);

    applyStimulus("illegal", 32'hFC000000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("illegal.IllegalConst", {31'd0, Illegal}, 32'd1);

    applyStimulus("regimmBad", 32'h04050004, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("lw", 32'h8C430010, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("sw", 32'hAC43FFF0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("jr", 32'h03E00008, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("noValid", 32'h00221820, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub", 32'h00221822, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("midReset", 32'h00221820, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("midReset.ValidConst", {31'd0, ValidOut}, 32'd0);
    applyStimulus("afterReset", 32'h00221824, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[31:26] = opList[$urandom_range(0, 15)];
      if (w[31:26] == 6'h00) w[5:0] = fnList[$urandom_range(0, 17)];
      if (w[31:26] == 6'h01 && $urandom_range(0, 3) != 0) w[20:16] = 5'($urandom_range(0, 1));
      applyStimulus($sformatf("rand%0d", i), w,
                    logic'($urandom_range(0, 9) < 8),
                    logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 9) == 0),
                    logic'($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_decoder.md
ID_EX_DECODER -- requirements
Module: id_ex_decoder

Interface
REQ-001 SHALL provide parameter RESET_CODE, default 5'b00000, ALUCode value driven while the stage holds a bubble.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 Instruction  input  32  IF/ID instruction word.
REQ-005 ValidIn  input  1  Instruction is valid this cycle.
REQ-006 Stall  input  1  hold the registered outputs.
REQ-007 Flush  input  1  replace the registered contents with a bubble.
REQ-008 ALUCode  output  5  registered ALU operation select, same encoding the ALU consumes.
REQ-009 ALUSrcA  output  1  registered: 1 means A operand = zero-extended Shamt (sll/srl/sra), 0 means A = rs.
REQ-010 ALUSrcB  output  1  registered: 1 means B operand = ImmExt.
REQ-011 ImmExt  output  32  registered extended immediate.
REQ-012 Shamt  output  5  registered Instruction[10:6].
REQ-013 RegWrite, RegDst, MemRead, MemWrite, OvfEn  output  1 each  registered controls; RegDst 1 means rd, 0 means rt.
REQ-014 ValidOut  output  1  registered: stage holds a real instruction.
REQ-015 Illegal  output  1  registered: held word decoded as unsupported.

Function
REQ-016 ALUCode encoding: add 00000, and 00001, xor 00010, or 00011, nor 00100, sub 00101, andi 00110, xori 00111, ori 01000, jr 01001, beq 01010, bne 01011, bgez 01100, bgtz 01101, blez 01110, bltz 01111, sll 10000, srl 10001, sra 10010, slt 10011, sltu 10100.
REQ-017 R-type (op 000000) by funct: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 000000/000100 sll, 000010/000110 srl, 000011/000111 sra, 001000 jr; RegDst 1; RegWrite 1 except jr.
REQ-018 ALUSrcA 1 only for funct 000000/000010/000011; variable shifts (sllv/srlv/srav) use ALUSrcA 0.
REQ-019 OvfEn 1 only for add (100000), sub (100010), addi; 0 for addu, subu, addiu and all others.
REQ-020 I-type: 001000/001001 add, 001100 andi, 001101 ori, 001110 xori, 001010 slt, 001011 sltu, 100011 lw (add, MemRead), 101011 sw (add, MemWrite, RegWrite 0); ALUSrcB 1, RegDst 0, RegWrite 1 except sw.
REQ-021 ImmExt: zero-extended Instruction[15:0] for andi/ori/xori, sign-extended otherwise.
REQ-022 Branches: 000100 beq, 000101 bne, 000110 blez, 000111 bgtz, 000001 with rt 00001 bgez, rt 00000 bltz; RegWrite 0, ALUSrcB 0.
REQ-023 Any other opcode, funct, or REGIMM rt: Illegal 1, ALUCode RESET_CODE, RegWrite/MemRead/MemWrite/OvfEn 0, ValidOut 1.
REQ-024 Latency: decode of Instruction sampled at edge N appears on outputs after edge N.
REQ-025 Per-edge priority: reset > Flush > Stall > load.
REQ-026 Load: when ValidIn is 1, register the decoded word; when ValidIn is 0, register a bubble.
REQ-027 Bubble: ALUCode RESET_CODE, all 1-bit outputs 0, ImmExt 0, Shamt 0.
REQ-028 Stall: all outputs hold their values, ValidIn ignored.
REQ-029 Flush with Stall in the same cycle: bubble.

Reset
REQ-030 At a reset edge, all outputs go to bubble values (REQ-027) and stay there while reset is high, regardless of other inputs.
REQ-031 The first load SHALL occur on the first edge with reset low.

Structure
REQ-032 ALUCode values, opcode/funct constants, and the control-bundle typedef SHALL live in shared package mips_pkg, also used by the ALU.
REQ-033 Combinational decode SHALL be sub-module id_decode_comb; this module SHALL add only the pipeline register and the priority logic.

Verification
REQ-034 Instruction 0x00221820 (add), ValidIn 1 -> next edge ALUCode 00000, RegWrite 1, RegDst 1, OvfEn 1, ValidOut 1.
REQ-035 0x3422FFFF (ori) -> ALUCode 01000, ALUSrcB 1, ImmExt 0x0000FFFF; 0x2022FFFF (addi) -> ImmExt 0xFFFFFFFF, OvfEn 1.
REQ-036 0x00021883 (sra, shamt 2) -> ALUCode 10010, ALUSrcA 1, Shamt 2; 0x04210004 (bgez) -> ALUCode 01100, RegWrite 0.
REQ-037 Stall held 3 cycles while Instruction changes -> outputs unchanged; Flush and Stall together -> bubble, ValidOut 0.
REQ-038 Opcode 111111 -> Illegal 1, RegWrite 0, ValidOut 1; reset asserted mid-stream -> bubble at the next edge.
